// File: rtl/conv_layer_ctrl.sv
// Weight loader and frame sequencer for one conv_layer instance.
// Define CONV_CTRL_WATCHDOG_EN to add a per-frame timeout that raises error_o.
module conv_layer_ctrl #(
  parameter  int KERNEL_HEIGHT  = 3,
  parameter  int KERNEL_WIDTH   = 2,
  parameter  int N_CONVOLUTIONS = 2,
  parameter  int WORD_SIZE      = 16,
  parameter  int FRAME_W        = 16,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int KS             = KERNEL_HEIGHT * KERNEL_WIDTH,
  localparam int WIDX_W         = $clog2(KS + 1),
  localparam int CIDX_W         = $clog2(N_CONVOLUTIONS + 1),
  localparam int ADDR_W         = CIDX_W + WIDX_W
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic [FRAME_W-1:0]   frames_i,
  input  logic                 valid_i,
  output logic                 yumi_o,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 wen_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  input  logic                 conv_ready_i,
  output logic                 start_o,
  output logic                 loaded_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [FRAME_W-1:0]   frame_count_o,
  output logic                 error_o
);

  typedef enum logic [2:0] {eIDLE, eLOAD, eARM, eSTART, eRUN, eDONE} state_e;

  state_e             state_reg;
  logic [WIDX_W-1:0]  word_idx_reg;
  logic [CIDX_W-1:0]  conv_idx_reg;
  logic [FRAME_W-1:0] frames_reg;
  logic               first_cycle_reg;
  logic               handshake;
  logic               accept_load;
  logic               accept_run;
  logic               last_word;
  logic               wd_fire;
  logic [FRAME_W:0]   frame_count_inc;

  assign handshake       = (state_reg == eLOAD) && valid_i;
  assign yumi_o          = handshake;
  assign busy_o          = (state_reg != eIDLE);
  assign accept_load     = (state_reg == eIDLE) && load_i;
  assign accept_run      = (state_reg == eIDLE) && !load_i && run_i && loaded_o;
  assign last_word       = (word_idx_reg == WIDX_W'(KS)) &&
                           (conv_idx_reg == CIDX_W'(N_CONVOLUTIONS - 1));
  assign frame_count_inc = {1'b0, frame_count_o} + 1'b1;

`ifdef CONV_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;

  // A frame that completes on the timeout cycle still counts as completed.
  assign wd_fire = (state_reg == eRUN) && !first_cycle_reg && !conv_ready_i &&
                   (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wd_cnt_reg <= '0;
      error_o    <= 1'b0;
    end else begin
      wd_cnt_reg <= (state_reg == eRUN) ? wd_cnt_reg + 1'b1 : '0;
      if (accept_load || accept_run) begin
        error_o <= 1'b0;
      end else if (wd_fire) begin
        error_o <= 1'b1;
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  // Constant-false comparison: keeps error_o at 0 without a watchdog.
  assign error_o = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg       <= eIDLE;
      word_idx_reg    <= '0;
      conv_idx_reg    <= '0;
      frames_reg      <= '0;
      first_cycle_reg <= 1'b0;
      wen_o           <= 1'b0;
      mem_addr_o      <= '0;
      mem_data_o      <= '0;
      start_o         <= 1'b0;
      loaded_o        <= 1'b0;
      done_o          <= 1'b0;
      frame_count_o   <= '0;
    end else begin
      wen_o   <= 1'b0;
      start_o <= 1'b0;
      done_o  <= 1'b0;
      case (state_reg)
        eIDLE: begin
          if (accept_load) begin
            state_reg    <= eLOAD;
            loaded_o     <= 1'b0;
            word_idx_reg <= '0;
            conv_idx_reg <= '0;
          end else if (accept_run) begin
            frames_reg    <= frames_i;
            frame_count_o <= '0;
            if (frames_i == '0) begin
              state_reg <= eDONE;
              done_o    <= 1'b1;
            end else begin
              state_reg <= eARM;
            end
          end
        end
        eLOAD: begin
          if (handshake) begin
            // Upper field is offset by one so address block 0 stays untouched.
            wen_o      <= 1'b1;
            mem_data_o <= data_i;
            mem_addr_o <= {CIDX_W'(conv_idx_reg + 1'b1), word_idx_reg};
            if (word_idx_reg == WIDX_W'(KS)) begin
              word_idx_reg <= '0;
              conv_idx_reg <= conv_idx_reg + 1'b1;
            end else begin
              word_idx_reg <= word_idx_reg + 1'b1;
            end
            if (last_word) begin
              state_reg <= eIDLE;
              loaded_o  <= 1'b1;
            end
          end
        end
        eARM: begin
          if (conv_ready_i) begin
            state_reg <= eSTART;
            start_o   <= 1'b1;
          end
        end
        eSTART: begin
          state_reg       <= eRUN;
          first_cycle_reg <= 1'b1;
        end
        eRUN: begin
          // The layer still shows ready during the first cycle after start.
          first_cycle_reg <= 1'b0;
          if (!first_cycle_reg && conv_ready_i) begin
            if (frame_count_o != '1) begin
              frame_count_o <= frame_count_o + 1'b1;
            end
            if (frame_count_inc == {1'b0, frames_reg}) begin
              state_reg <= eDONE;
              done_o    <= 1'b1;
            end else begin
              state_reg <= eSTART;
              start_o   <= 1'b1;
            end
          end else if (wd_fire) begin
            state_reg <= eDONE;
            done_o    <= 1'b1;
          end
        end
        eDONE: begin
          state_reg <= eIDLE;
        end
        default: begin
          state_reg <= eIDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl: spec-level model, per-cycle compare, directed tests.
module tb_conv_layer_ctrl;

  localparam int TO = 16;
`ifdef CONV_CTRL_WATCHDOG_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 20;
`endif

  logic        clk_i;
  logic        reset_ni;
  logic        load_i;
  logic        run_i;
  logic [15:0] frames_i;
  logic        valid_i;
  logic        yumi_o;
  logic [15:0] data_i;
  logic [4:0]  mem_addr_o;
  logic        wen_o;
  logic [15:0] mem_data_o;
  logic        conv_ready_i;
  logic        start_o;
  logic        loaded_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] frame_count_o;
  logic        error_o;

  conv_layer_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .load_i(load_i), .run_i(run_i),
    .frames_i(frames_i), .valid_i(valid_i), .yumi_o(yumi_o), .data_i(data_i),
    .mem_addr_o(mem_addr_o), .wen_o(wen_o), .mem_data_o(mem_data_o),
    .conv_ready_i(conv_ready_i), .start_o(start_o), .loaded_o(loaded_o),
    .busy_o(busy_o), .done_o(done_o), .frame_count_o(frame_count_o), .error_o(error_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 running (arm/start/run/done)
  int   m_phase, m_words, m_tgt, m_fc, m_rc;
  bit   m_loaded, m_arm, m_in_run, m_cnt_pend, m_err;
  bit   exp_wen, exp_start, exp_done;
  logic [4:0]  exp_addr;
  logic [15:0] exp_data;
  bit   lay_drop, layer_stuck;
  int   lay_busy;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_phase = 0; m_words = 0; m_tgt = 0; m_fc = 0; m_rc = 0;
      m_loaded = 0; m_arm = 0; m_in_run = 0; m_cnt_pend = 0; m_err = 0;
      exp_wen = 0; exp_start = 0; exp_done = 0; exp_addr = '0; exp_data = '0;
      lay_drop = 0; lay_busy = 0;
      conv_ready_i <= 1'b1;
    end else begin
      bit done_was, start_was;
      done_was  = exp_done;
      start_was = exp_start;
      exp_wen = 0; exp_start = 0; exp_done = 0;
      case (m_phase)
        0: begin
          if (load_i) begin
            m_phase = 1; m_words = 0; m_loaded = 0; m_err = 0;
          end else if (run_i && m_loaded) begin
            m_err = 0; m_tgt = frames_i; m_fc = 0; m_phase = 2;
            if (frames_i == 16'd0) exp_done = 1;
            else m_arm = 1;
          end
        end
        1: begin
          if (valid_i) begin
            exp_wen  = 1;
            exp_addr = 5'(((m_words / 7) + 1) * 8 + (m_words % 7));
            exp_data = data_i;
            m_words++;
            if (m_words == 14) begin
              m_loaded = 1;
              m_phase  = 0;
            end
          end
        end
        default: begin
          if (done_was) begin
            m_phase = 0;
          end else if (m_arm) begin
            if (conv_ready_i) begin
              exp_start = 1;
              m_arm = 0;
            end
          end else if (start_was) begin
            m_in_run = 1;
            m_rc = 0;
          end else if (m_in_run) begin
            m_rc++;
            if (m_cnt_pend) begin
              m_in_run = 0;
              m_fc++;
              if (m_fc == m_tgt) exp_done = 1;
              else exp_start = 1;
            end
`ifdef CONV_CTRL_WATCHDOG_EN
            else if (m_rc == TO) begin
              m_in_run = 0;
              exp_done = 1;
              m_err = 1;
            end
`endif
          end
        end
      endcase
      // layer stand-in: drop ready one cycle after start, raise it LAT cycles later
      m_cnt_pend = 0;
      if (lay_drop) begin
        lay_drop = 0;
        conv_ready_i <= 1'b0;
        lay_busy = LAT;
      end else if (lay_busy > 0) begin
        lay_busy--;
        if (lay_busy == 0 && !layer_stuck) begin
          conv_ready_i <= 1'b1;
          m_cnt_pend = 1;
        end
      end
      if (start_o) lay_drop = 1;
    end
  end

  int cyc_n = 0, starts_n = 0, dones_n = 0, last_start = 0, last_done = 0, wr_n = 0;
  logic [4:0]  wr_addr [0:63];
  logic [15:0] wr_data [0:63];

  always @(negedge clk_i) begin
    if (reset_ni) begin
      chk("yumi", yumi_o, (m_phase == 1) && valid_i);
      chk("wen", wen_o, exp_wen);
      if (exp_wen) begin
        chk("mem_addr", mem_addr_o, exp_addr);
        chk("mem_data", mem_data_o, exp_data);
      end
      chk("loaded", loaded_o, m_loaded);
      chk("busy", busy_o, m_phase != 0);
      chk("start", start_o, exp_start);
      chk("done", done_o, exp_done);
      chk("frame_count", frame_count_o, m_fc);
      chk("error", error_o, m_err);
      cyc_n++;
      if (wen_o && wr_n < 64) begin
        wr_addr[wr_n] = mem_addr_o;
        wr_data[wr_n] = mem_data_o;
        wr_n++;
      end
      if (start_o) begin starts_n++; last_start = cyc_n; end
      if (done_o)  begin dones_n++;  last_done  = cyc_n; end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic stream(input logic [15:0] base, input bit bursty, input int count);
    int n, c;
    n = 0; c = 0;
    while (n < count && c < 400) begin
      valid_i = bursty ? ((c % 2) == 0) : 1'b1;
      data_i  = base + 16'(n);
      tick();
      if (valid_i) n++;
      c++;
    end
    if (n < count) chk("stream_budget", n, count);
  endtask

  task automatic do_load(input logic [15:0] base, input bit bursty, input bit with_run);
    wr_n = 0;
    load_i = 1'b1; run_i = with_run; frames_i = 16'd1;
    tick();
    load_i = 1'b0; run_i = 1'b0;
    stream(base, bursty, 14);
    valid_i = 1'b0;
    tick(); tick();
  endtask

  task automatic check_log(input string tag, input logic [15:0] base);
    chk({tag, "_writes"}, wr_n, 14);
    chk({tag, "_addr0"}, wr_addr[0], 5'h08);
    chk({tag, "_addr6"}, wr_addr[6], 5'h0E);
    chk({tag, "_addr7"}, wr_addr[7], 5'h10);
    chk({tag, "_addr13"}, wr_addr[13], 5'h16);
    chk({tag, "_data0"}, wr_data[0], base);
    chk({tag, "_data13"}, wr_data[13], base + 16'd13);
    chk({tag, "_loaded"}, loaded_o, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_yumi"}, yumi_o, 1'b0);
    chk({tag, "_wen"}, wen_o, 1'b0);
    chk({tag, "_addr"}, mem_addr_o, 5'h00);
    chk({tag, "_data"}, mem_data_o, 16'h0000);
    chk({tag, "_loaded"}, loaded_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_start"}, start_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_frames"}, frame_count_o, 16'h0000);
  endtask

  task automatic run_and_wait(input logic [15:0] n, input int budget);
    int d0;
    d0 = dones_n;
    run_i = 1'b1; frames_i = n;
    tick();
    run_i = 1'b0;
    for (int i = 0; i < budget && dones_n == d0; i++) tick();
  endtask

  initial begin
    int s0, d0;
    load_i = 0; run_i = 0; frames_i = 0; valid_i = 0; data_i = 0; layer_stuck = 0;
    reset_ni = 1'b1;
    #1 reset_ni = 1'b0;
    #12;
    check_reset_outputs("reset");
    chk("reset_error", error_o, 1'b0);
    @(posedge clk_i); #2 reset_ni = 1'b1;
    tick();

    // run before any load is ignored
    s0 = starts_n;
    run_i = 1'b1; frames_i = 16'd2;
    tick();
    run_i = 1'b0;
    repeat (5) tick();
    chk("noload_starts", starts_n - s0, 0);
    chk("noload_busy", busy_o, 1'b0);

    do_load(16'h0100, 1'b0, 1'b0);
    check_log("load", 16'h0100);

    do_load(16'h0200, 1'b1, 1'b0);
    check_log("bursty", 16'h0200);
    chk("bursty_data3", wr_data[3], 16'h0203);

    s0 = starts_n; d0 = dones_n;
    run_and_wait(16'd3, 400);
    chk("run3_done", dones_n - d0, 1);
    chk("run3_starts", starts_n - s0, 3);
    chk("run3_count", frame_count_o, 16'd3);
    tick();
    chk("run3_busy_after", busy_o, 1'b0);
    chk("run3_single_done", dones_n - d0, 1);

    // zero frames: done within two cycles, no start
    s0 = starts_n; d0 = dones_n;
    run_i = 1'b1; frames_i = 16'd0;
    tick();
    run_i = 1'b0;
    tick();
    chk("zero_done", dones_n - d0, 1);
    chk("zero_starts", starts_n - s0, 0);
    chk("zero_busy", busy_o, 1'b0);

    // load and run together: load wins
    s0 = starts_n;
    do_load(16'h0300, 1'b0, 1'b1);
    check_log("loadrun", 16'h0300);
    chk("loadrun_starts", starts_n - s0, 0);

    // async reset in the middle of a load
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    stream(16'h0400, 1'b0, 5);
    #1 reset_ni = 1'b0;
    #1 check_reset_outputs("rst_load");
    valid_i = 1'b0;
    @(posedge clk_i); #2 reset_ni = 1'b1;
    tick();
    chk("rst_load_loaded_after", loaded_o, 1'b0);

    // async reset in the middle of a run
    do_load(16'h0500, 1'b0, 1'b0);
    run_i = 1'b1; frames_i = 16'd3;
    tick();
    run_i = 1'b0;
    repeat (30) tick();
    chk("rst_run_busy_before", busy_o, 1'b1);
    #1 reset_ni = 1'b0;
    #1 check_reset_outputs("rst_run");
    @(posedge clk_i); #2 reset_ni = 1'b1;
    tick();

    // layer never finishes
    do_load(16'h0600, 1'b0, 1'b0);
    layer_stuck = 1'b1;
    d0 = dones_n;
`ifdef CONV_CTRL_WATCHDOG_EN
    run_and_wait(16'd1, 100);
    tick();
    chk("wd_done", dones_n - d0, 1);
    chk("wd_latency", last_done - last_start, TO + 1);
    chk("wd_error", error_o, 1'b1);
    chk("wd_count_held", frame_count_o, 16'd0);
`else
    run_i = 1'b1; frames_i = 16'd1;
    tick();
    run_i = 1'b0;
    repeat (60) tick();
    chk("stuck_busy", busy_o, 1'b1);
    chk("stuck_error", error_o, 1'b0);
    chk("stuck_no_done", dones_n - d0, 0);
`endif
    layer_stuck = 1'b0;
    #1 reset_ni = 1'b0;
    #1 check_reset_outputs("final");
    @(posedge clk_i); #2 reset_ni = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
- Sequencer for one convolutional layer. Loads kernel and bias words from a ready/valid stream into the layer's kernel RAMs through the layer's write port (`mem_addr`/`wen`/`mem_data`).
- Then issues `start` pulses to run a programmed number of input frames through the layer, tracking completion via the layer's `conv_ready`.
- Sits between the top-level configuration/scheduler and each `conv_layer` instance.

Parameters:
- KERNEL_HEIGHT, 3, kernel height of the controlled layer
- KERNEL_WIDTH, 2, kernel width of the controlled layer
- N_CONVOLUTIONS, 2, number of kernels in the layer
- WORD_SIZE, 16, data word width
- FRAME_W, 16, width of frame count
- TIMEOUT_CYCLES, 4096, watchdog limit per frame (used only with the optional feature)

Derived values:
- KS = KERNEL_HEIGHT*KERNEL_WIDTH
- WIDX_W = $clog2(KS+1)
- CIDX_W = $clog2(N_CONVOLUTIONS+1)
- ADDR_W = CIDX_W+WIDX_W

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- load_i  in  1  request weight load (sampled in eIDLE)
- run_i  in  1  request frame run (sampled in eIDLE)
- frames_i  in  FRAME_W  number of frames to run, latched on accepted run_i
- valid_i  in  1  weight word valid
- yumi_o  out  1  weight word consumed
- data_i  in  WORD_SIZE  weight word
- mem_addr_o  out  ADDR_W  layer RAM address, {conv_idx+1, word_idx}
- wen_o  out  1  layer RAM write enable
- mem_data_o  out  WORD_SIZE  layer RAM write data
- conv_ready_i  in  1  layer idle/ready
- start_o  out  1  layer start pulse
- loaded_o  out  1  all weights written since last reset/load
- busy_o  out  1  state != eIDLE
- done_o  out  1  one-cycle pulse, run finished
- frame_count_o  out  FRAME_W  frames completed in current/last run
- error_o  out  1  sticky watchdog error (tied 0 without the optional feature)

Behaviour:
- **Reset:** reset_ni low asynchronously forces state eIDLE and zeroes all counters and registered outputs (yumi_o, wen_o, mem_addr_o, mem_data_o, start_o, loaded_o, done_o, frame_count_o, error_o = 0).
  - Reset mid-load or mid-run abandons the operation; loaded_o is cleared.
- **States:** eIDLE, eLOAD, eARM, eSTART, eRUN, eDONE.
- **eIDLE:**
  - load_i → eLOAD: clears loaded_o, word_idx and conv_idx.
  - Else run_i with loaded_o=1 → eARM: latches frames_i, clears frame_count_o.
  - run_i with frames_i=0 → eDONE directly.
  - run_i with loaded_o=0 is ignored.
  - If load_i and run_i are both high, load wins.
- **eLOAD:**
  - yumi_o = valid_i (combinational). No other state asserts yumi_o.
  - Each handshake registers wen_o=1, mem_data_o=data_i and mem_addr_o={conv_idx+1, word_idx} for exactly the following cycle; write latency is 1 cycle.
  - wen_o=0 when there is no handshake; mem_addr_o and mem_data_o hold their values.
  - word_idx counts 0..KS; word KS is the bias. At KS it wraps to 0 and conv_idx increments.
  - On the handshake of conv_idx=N_CONVOLUTIONS-1, word_idx=KS → eIDLE, and loaded_o=1 in the same cycle the final wen_o is high.
  - Upper address field 0 is never emitted.
- **eARM:** wait until conv_ready_i=1 → eSTART.
- **eSTART:** start_o=1 for exactly one cycle → eRUN.
- **eRUN:**
  - conv_ready_i is ignored in the first cycle of eRUN (the layer drops it one cycle after start).
  - Afterwards, conv_ready_i=1 marks frame complete and frame_count_o increments.
  - If frame_count_o+1 == latched frames → eDONE, else → eSTART.
  - frame_count_o saturates at 2^FRAME_W-1.
- **eDONE:** done_o=1 one cycle → eIDLE.
- load_i and run_i outside eIDLE are ignored.
- busy_o is combinational from state.

Optional Feature:
- Macro CONV_CTRL_WATCHDOG_EN.
- **Defined:** a cycle counter clears on entering eRUN and counts while in eRUN. Reaching TIMEOUT_CYCLES before the frame completes sets error_o (sticky until reset or next accepted load_i/run_i). The state goes to eDONE, done_o pulses, and frame_count_o holds.
- **Undefined:** no counter is built, error_o is tied 0, and eRUN waits indefinitely.

Test Plan:
1. **Load:** reset, load_i, stream 14 words 0x0100..0x010D with valid_i always 1.
   - Required: 14 wen_o pulses.
   - Word 0 at addr 0x08, word 6 at 0x0E, word 7 at 0x10, word 13 at 0x16.
   - loaded_o=1 with the last write.
2. **Bursty load:** valid_i toggled 1/0 each cycle.
   - Required: yumi_o only when valid_i=1, addresses contiguous with no skips, 14 writes total.
3. **Run:** frames_i=3, with a layer model dropping conv_ready 1 cycle after start and raising it 20 cycles later.
   - Required: 3 start_o pulses, frame_count_o ends at 3, one done_o pulse, busy_o low afterwards.
4. **Guard cases:**
   - run_i before load → stays eIDLE with no start_o.
   - frames_i=0 → done_o within 2 cycles, no start_o.
   - load_i and run_i together → load performed.
5. **Async reset:** reset_ni asserted mid-eLOAD (after 5 words) and mid-eRUN.
   - Required: outputs 0 immediately without a clock edge, and loaded_o=0.
6. **Watchdog:** with CONV_CTRL_WATCHDOG_EN and TIMEOUT_CYCLES=16, conv_ready_i held low.
   - Required: error_o=1 and done_o pulse 16 cycles into eRUN.
   - Without the macro, the controller remains in eRUN with error_o=0.
